// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
// LOADER_CHECKSUM_EN adds the trailing XOR checksum state.
package loader_pkg;
   localparam int INSTR_W        = 19;
   localparam int BYTES_PER_WORD = 3;
   localparam int LEN_W          = 16;

   // Bits of the final byte of a word that land in the instruction word
   localparam int TOP_BITS = INSTR_W - 8*(BYTES_PER_WORD-1);

   typedef enum logic [3:0] {
      IDLE, LEN0, LEN1, B0, B1, B2, WRITE,
`ifdef LOADER_CHECKSUM_EN
      CSUM,
`endif
      DONE, ERR
   } state_t;
endpackage

// File: rtl/imem_loader.sv
// Loads N 19-bit instruction words from a byte stream into instruction memory,
// holding the CPU meanwhile. Optional trailing checksum via LOADER_CHECKSUM_EN.
module imem_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               in_valid,
   input  logic [7:0]         in_data,
   output logic               in_ready,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [INSTR_W-1:0] mem_wdata,
   output logic               cpu_hold,
   output logic               busy,
   output logic               done,
   output logic               err
);

   state_t           state, nxt;
   logic [7:0]       len_lo, b0, b1;
   logic [LEN_W-1:0] rem;
   logic [LEN_W-1:0] len_n;
   logic             accept, len_bad, b2_bad, last, sess_start;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]       csum;
`endif

   assign accept     = in_valid & in_ready;
   assign len_n      = {in_data, len_lo};
   assign len_bad    = (len_n == '0) || ({1'b0, len_n} > (LEN_W+1)'(DEPTH));
   assign b2_bad     = |in_data[7:TOP_BITS];
   assign last       = (rem == LEN_W'(1));
   assign sess_start = start && (state == IDLE || state == ERR);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE, ERR: if (start)  nxt = LEN0;
         LEN0:      if (accept) nxt = LEN1;
         LEN1:      if (accept) nxt = len_bad ? ERR : B0;
         B0:        if (accept) nxt = B1;
         B1:        if (accept) nxt = B2;
         B2:        if (accept) nxt = b2_bad ? ERR : WRITE;
`ifdef LOADER_CHECKSUM_EN
         WRITE:     nxt = last ? CSUM : B0;
         CSUM:      if (accept) nxt = (in_data == csum) ? DONE : ERR;
`else
         WRITE:     nxt = last ? DONE : B0;
`endif
         DONE:      nxt = IDLE;
         default:   nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      case (state)
         LEN0, LEN1, B0, B1, B2: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
         CSUM:                   in_ready = 1'b1;
`endif
         default:                in_ready = 1'b0;
      endcase
      mem_we   = (state == WRITE);
      cpu_hold = (state != IDLE);
      busy     = (state != IDLE) && (state != ERR);
      done     = (state == DONE);
      err      = (state == ERR);
   end

   // Address stops on the last word so a full DEPTH load never wraps it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         len_lo    <= '0;
         b0        <= '0;
         b1        <= '0;
         rem       <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         if (sess_start) begin
            rem      <= '0;
            mem_addr <= '0;
         end
         if (accept) begin
            case (state)
               LEN0:    len_lo <= in_data;
               LEN1:    rem    <= len_n;
               B0:      b0     <= in_data;
               B1:      b1     <= in_data;
               B2:      if (!b2_bad) mem_wdata <= {in_data[TOP_BITS-1:0], b1, b0};
               default: ;
            endcase
         end
         if (state == WRITE) begin
            rem <= rem - LEN_W'(1);
            if (!last) mem_addr <= mem_addr + ADDR_W'(1);
         end
      end
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)          csum <= '0;
      else if (sess_start) csum <= '0;
      else if (accept)     csum <= csum ^ in_data;
   end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: stimulus pushes expected writes into a queue,
// a negedge monitor pops and compares every mem_we strobe.
module tb_imem_loader;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 256;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready, mem_we, cpu_hold, busy, done, err;
   logic [ADDR_W-1:0] mem_addr;
   logic [18:0]       mem_wdata;

   imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [18:0]       data;
   } wr_t;

   wr_t        exp_q[$];
   wr_t        exp_e;
   logic [7:0] stream[$];
   int         n_cmp = 0, n_bad = 0, n_wr = 0, n_done = 0;

   // Monitor: every write strobe is checked against the scoreboard
   always @(negedge clk) begin
      if (reset) begin
         if (done) n_done++;
         if (mem_we) begin
            n_wr++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_write: got addr %h data %h, none expected", mem_addr, mem_wdata);
            end else begin
               exp_e = exp_q.pop_front();
               if (mem_addr !== exp_e.addr || mem_wdata !== exp_e.data) begin
                  n_bad++;
                  $display("FAIL mem_write: got addr %h data %h, want addr %h data %h",
                           mem_addr, mem_wdata, exp_e.addr, exp_e.data);
               end
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask

   task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [18:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      exp_q.push_back(w);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL byte_timeout: got in_ready 0 want 1 for byte %h", b);
      end
      tick();
      in_valid = 1'b0;
   endtask

   // Sends the queued stream; optionally toggles in_valid and appends the XOR checksum
   task automatic send_stream(input bit stall, input bit add_csum);
      logic [7:0] x = 8'h00;
      foreach (stream[i]) begin
         send_byte(stream[i]);
         x = x ^ stream[i];
         if (stall) tick();
      end
`ifdef LOADER_CHECKSUM_EN
      if (add_csum) send_byte(x);
`else
      if (add_csum) x = 8'h00;
`endif
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy && n < 60) begin
         tick();
         n++;
      end
      chk({nm, "_idle"}, 64'(busy), 64'd0);
   endtask

   int d0, w0;

   initial begin
      tick();
      chk("reset_outputs", {in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err}, 64'd0);
      reset = 1'b1;
      tick();
      chk("post_reset_idle", {in_ready, cpu_hold, busy, done, err}, 64'd0);

      // Two words, continuous valid
      d0 = n_done;
      push_wr(8'd0, 19'h00001);
      push_wr(8'd1, 19'h7FFFF);
      do_start();
      chk("s1_busy", {cpu_hold, busy, in_ready}, 64'b111);
      stream = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h07};
      send_stream(1'b0, 1'b1);
      wait_idle("s1");
      chk("s1_done", 64'(n_done - d0), 64'd1);
      chk("s1_hold", {cpu_hold, err}, 64'd0);
      chk("s1_drained", 64'(exp_q.size()), 64'd0);

      // Same stream with in_valid toggled every other cycle
      d0 = n_done;
      push_wr(8'd0, 19'h00001);
      push_wr(8'd1, 19'h7FFFF);
      do_start();
      send_stream(1'b1, 1'b1);
      wait_idle("s2");
      chk("s2_done", 64'(n_done - d0), 64'd1);
      chk("s2_drained", 64'(exp_q.size()), 64'd0);

      // Zero length -> ERR, then recover with a good stream
      w0 = n_wr;
      do_start();
      stream = '{8'h00, 8'h00};
      send_stream(1'b0, 1'b0);
      tick();
      chk("s3_err", {err, cpu_hold, busy, in_ready}, 64'b1100);
      chk("s3_nowrite", 64'(n_wr - w0), 64'd0);
      d0 = n_done;
      push_wr(8'd0, 19'h00001);
      push_wr(8'd1, 19'h7FFFF);
      do_start();
      chk("s3_err_cleared", 64'(err), 64'd0);
      stream = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h07};
      send_stream(1'b0, 1'b1);
      wait_idle("s3b");
      chk("s3_recover_done", {28'(n_done - d0), err}, {28'd1, 1'b0});

      // Length above DEPTH -> ERR
      do_start();
      stream = '{8'h01, 8'h01};
      send_stream(1'b0, 1'b0);
      tick();
      chk("s3c_len_over", 64'(err), 64'd1);

      // Illegal high bits in the third byte
      w0 = n_wr;
      do_start();
      stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h08};
      send_stream(1'b0, 1'b0);
      tick();
      chk("s4_err", {err, cpu_hold}, 64'b11);
      chk("s4_nowrite", 64'(n_wr - w0), 64'd0);

      // Reset pulled mid-session right after the first write
      push_wr(8'd0, 19'h00001);
      do_start();
      stream = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h00};
      send_stream(1'b0, 1'b0);
      chk("s5_in_write", 64'(mem_we), 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("s5_reset_outputs", {in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err}, 64'd0);
      tick();
      reset = 1'b1;
      tick();
      d0 = n_done;
      push_wr(8'd0, 19'h00003);
      do_start();
      stream = '{8'h01, 8'h00, 8'h03, 8'h00, 8'h00};
      send_stream(1'b0, 1'b1);
      wait_idle("s5b");
      chk("s5_restart_done", 64'(n_done - d0), 64'd1);

`ifdef LOADER_CHECKSUM_EN
      d0 = n_done;
      push_wr(8'd0, 19'h00005);
      do_start();
      stream = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h04};
      send_stream(1'b0, 1'b0);
      wait_idle("s6");
      chk("s6_csum_ok", {28'(n_done - d0), err}, {28'd1, 1'b0});
      d0 = n_done;
      push_wr(8'd0, 19'h00005);
      do_start();
      stream = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h05};
      send_stream(1'b0, 1'b0);
      tick();
      chk("s6_csum_bad", {28'(n_done - d0), err}, {28'd0, 1'b1});
`endif

      tick();
      chk("final_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
